// File: rtl/prio_ic_pkg.sv
// rtl/prio_ic_pkg.sv - shared types and register offsets for the priority interrupt controller
package prio_ic_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESENT    = 2'd1,
        IN_SERVICE = 2'd2
    } state_e;

    // Control register word offsets, added to NUM_SRC (PRIO[i] occupy 0..NUM_SRC-1)
    localparam int OFF_ENABLE  = 0;
    localparam int OFF_MODE    = 1;
    localparam int OFF_PENDING = 2;
    localparam int OFF_THRESH  = 3;
    localparam int OFF_STATUS  = 4;

    localparam int STATUS_BUSY_BIT = 8;

endpackage

// File: rtl/prio_ic_arbiter.sv
// rtl/prio_ic_arbiter.sv - combinational highest-priority picker, ties to lowest index
module prio_ic_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    localparam int ID_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]        elig,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_flat,
    output logic [ID_W-1:0]           winner,
    output logic                      any_elig
);

    logic [PRIO_W-1:0] best;

    // Scan upward; strict greater-than keeps the lowest index on equal priority
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        best     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && (!any_elig || (prio_flat[i*PRIO_W +: PRIO_W] > best))) begin
                any_elig = 1'b1;
                winner   = ID_W'(i);
                best     = prio_flat[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/prio_interrupt_controller.sv
// rtl/prio_interrupt_controller.sv - APB-programmable priority interrupt controller top
module prio_interrupt_controller
    import prio_ic_pkg::*;
#(
    parameter int NUM_SRC  = 8,
    parameter int PRIO_W   = 3,
    localparam int ID_W    = $clog2(NUM_SRC),
    localparam int ADDR_W  = $clog2(NUM_SRC + 8)
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack,
    input  logic              irq_done
);

    localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(NUM_SRC + OFF_ENABLE);
    localparam logic [ADDR_W-1:0] A_MODE    = ADDR_W'(NUM_SRC + OFF_MODE);
    localparam logic [ADDR_W-1:0] A_PENDING = ADDR_W'(NUM_SRC + OFF_PENDING);
    localparam logic [ADDR_W-1:0] A_THRESH  = ADDR_W'(NUM_SRC + OFF_THRESH);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(NUM_SRC + OFF_STATUS);

    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] src_hist_q, src_hist_d;
    logic [PRIO_W-1:0]  thresh_q, thresh_d;
    state_e             state_q, state_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [ID_W-1:0]    in_service_q, in_service_d;
    logic [31:0]        prdata_q, prdata_d;

    logic               acc, err, wr, rd;
    logic [NUM_SRC-1:0] elig, w1c_mask, claim_mask, edge_next;
    logic [ID_W-1:0]    winner;
    logic               any_elig, claim;
    logic [31:0]        rdata;
    logic               unused_pwdata;

    assign acc     = psel & penable;
    assign err     = acc & (paddr > A_STATUS);
    assign wr      = acc & pwrite & ~err;
    assign rd      = acc & ~pwrite;
    assign pready  = acc;
    assign pslverr = err;

    assign prdata    = prdata_q;
    assign irq_valid = (state_q == PRESENT);
    assign irq_id    = irq_id_q;

    assign unused_pwdata = ^pwdata;

    // Writable configuration registers; changes reach eligibility on the following cycle
    always_comb begin
        prio_d   = prio_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        if (wr) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (paddr == ADDR_W'(i)) prio_d[i] = pwdata[PRIO_W-1:0];
            end
            if (paddr == A_ENABLE) enable_d = pwdata[NUM_SRC-1:0];
            if (paddr == A_MODE)   mode_d   = pwdata[NUM_SRC-1:0];
            if (paddr == A_THRESH) thresh_d = pwdata[PRIO_W-1:0];
        end
    end

    // Pending capture: level bits follow the line, edge bits latch rises and a new rise beats a clear
    always_comb begin
        claim      = (state_q == PRESENT) && irq_ack;
        claim_mask = claim ? (NUM_SRC'(1) << irq_id_q) : '0;
        w1c_mask   = (wr && (paddr == A_PENDING)) ? pwdata[NUM_SRC-1:0] : '0;
        edge_next  = (pending_q & ~(w1c_mask | claim_mask)) | (irq_src & ~src_hist_q);
        pending_d  = (mode_q & edge_next) | (~mode_q & irq_src);
        src_hist_d = irq_src;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
        end
    end

    prio_ic_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arbiter (
        .elig      (elig),
        .prio_flat (prio_q),
        .winner    (winner),
        .any_elig  (any_elig)
    );

    // Offer/claim/complete sequencing; the offered id tracks the winner until claimed
    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d  = PRESENT;
                    irq_id_d = winner;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    in_service_d = irq_id_q;
                    state_d      = IN_SERVICE;
                end else if (any_elig) begin
                    irq_id_d = winner;
                end else begin
                    state_d = IDLE;
                end
            end
            IN_SERVICE: begin
                if (irq_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data mux; holds the last value outside a read access, unmapped reads give 0
    always_comb begin
        rdata = '0;
        if (!err) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (paddr == ADDR_W'(i)) rdata[PRIO_W-1:0] = prio_q[i];
            end
            if (paddr == A_ENABLE)  rdata[NUM_SRC-1:0] = enable_q;
            if (paddr == A_MODE)    rdata[NUM_SRC-1:0] = mode_q;
            if (paddr == A_PENDING) rdata[NUM_SRC-1:0] = pending_q;
            if (paddr == A_THRESH)  rdata[PRIO_W-1:0]  = thresh_q;
            if (paddr == A_STATUS) begin
                rdata[STATUS_BUSY_BIT] = (state_q == IN_SERVICE);
                rdata[ID_W-1:0]        = in_service_q;
            end
        end
        prdata_d = rd ? rdata : prdata_q;
    end

    // All state registers with synchronous active-high reset
    always_ff @(posedge pclk) begin
        if (preset) begin
            prio_q       <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            pending_q    <= '0;
            src_hist_q   <= '0;
            thresh_q     <= '0;
            state_q      <= IDLE;
            irq_id_q     <= '0;
            in_service_q <= '0;
            prdata_q     <= '0;
        end else begin
            prio_q       <= prio_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            src_hist_q   <= src_hist_d;
            thresh_q     <= thresh_d;
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
            prdata_q     <= prdata_d;
        end
    end

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// tb/tb_prio_interrupt_controller.sv - directed self-checking bench for prio_interrupt_controller
module tb_prio_interrupt_controller;

    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 3;
    localparam int ADDR_W  = 4;

    localparam logic [ADDR_W-1:0] A_ENABLE  = 4'd8;
    localparam logic [ADDR_W-1:0] A_MODE    = 4'd9;
    localparam logic [ADDR_W-1:0] A_PENDING = 4'd10;
    localparam logic [ADDR_W-1:0] A_THRESH  = 4'd11;
    localparam logic [ADDR_W-1:0] A_STATUS  = 4'd12;

    logic              pclk = 1'b0;
    logic              preset;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready, pslverr;
    logic [NUM_SRC-1:0] irq_src;
    logic              irq_valid;
    logic [ID_W-1:0]   irq_id;
    logic              irq_ack, irq_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       exp;
        logic              exp_err;
    } reg_vec_t;

    reg_vec_t vecs[10];

    prio_interrupt_controller #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .irq_src   (irq_src),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        preset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        irq_ack = 1'b0; irq_done = 1'b0;
        step();
        preset = 1'b0;
    endtask

    task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        step();
        penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        step();
        penable = 1'b1;
        #1;
        e = pslverr;
        chk("pready", {31'd0, pready}, 32'd1);
        step();
        d = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(a, d, e);
        chk(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;

        vecs[0] = '{4'd0,  32'hFFFF_FFFF, 32'h7,  1'b0};
        vecs[1] = '{4'd3,  32'h0000_000D, 32'h5,  1'b0};
        vecs[2] = '{4'd7,  32'h0000_0002, 32'h2,  1'b0};
        vecs[3] = '{A_ENABLE,  32'hFFFF_FF5A, 32'h5A, 1'b0};
        vecs[4] = '{A_MODE,    32'hABCD_0000, 32'h0,  1'b0};
        vecs[5] = '{A_MODE,    32'h0000_12C3, 32'hC3, 1'b0};
        vecs[6] = '{A_THRESH,  32'h0000_000E, 32'h6,  1'b0};
        vecs[7] = '{A_STATUS,  32'hFFFF_FFFF, 32'h0,  1'b0};
        vecs[8] = '{A_PENDING, 32'h0000_00FF, 32'h0,  1'b0};
        vecs[9] = '{4'd13,     32'h0000_0005, 32'h0,  1'b1};

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; irq_src = '0; irq_ack = 1'b0; irq_done = 1'b0;
        step();
        step();
        preset = 1'b0;

        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pready", {31'd0, pready}, 32'h0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'h0);
        chk("rst_irq_valid", {31'd0, irq_valid}, 32'h0);
        chk("rst_irq_id", {29'd0, irq_id}, 32'h0);

        // Register write/read-back table
        for (int i = 0; i < 10; i++) begin
            apb_write(vecs[i].addr, vecs[i].wdata);
            apb_read(vecs[i].addr, d, e);
            chk($sformatf("reg_vec%0d_data", i), d, vecs[i].exp);
            chk($sformatf("reg_vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
        end

        // Two level sources, priority order and re-offer after done
        do_reset();
        apb_write(4'd2, 32'd5);
        apb_write(4'd6, 32'd3);
        apb_write(A_ENABLE, 32'h44);
        irq_src = 8'h44;
        step();
        chk("s1_valid_e1", {31'd0, irq_valid}, 32'h0);
        step();
        chk("s1_valid_e2", {31'd0, irq_valid}, 32'h1);
        chk("s1_id_e2", {29'd0, irq_id}, 32'd2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("s1_valid_claimed", {31'd0, irq_valid}, 32'h0);
        read_chk("s1_status", A_STATUS, 32'h102);
        irq_src = 8'h40;
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        chk("s1_valid_after_done", {31'd0, irq_valid}, 32'h0);
        step();
        chk("s1_valid_reoffer", {31'd0, irq_valid}, 32'h1);
        chk("s1_id_reoffer", {29'd0, irq_id}, 32'd6);

        // Tie to lowest index, then threshold suppresses the offer
        do_reset();
        apb_write(4'd1, 32'd4);
        apb_write(4'd4, 32'd4);
        apb_write(A_ENABLE, 32'h12);
        irq_src = 8'h12;
        step();
        step();
        chk("s2_valid", {31'd0, irq_valid}, 32'h1);
        chk("s2_id_tie", {29'd0, irq_id}, 32'd1);
        apb_write(A_THRESH, 32'd4);
        chk("s2_valid_commit_edge", {31'd0, irq_valid}, 32'h1);
        step();
        chk("s2_valid_thresh", {31'd0, irq_valid}, 32'h0);
        step(); step(); step();
        chk("s2_valid_stays_low", {31'd0, irq_valid}, 32'h0);

        // Edge capture, W1C, and a rise coinciding with a clear
        do_reset();
        irq_src = '0;
        apb_write(A_MODE, 32'h8);
        irq_src = 8'h08;
        step();
        irq_src = 8'h00;
        step();
        read_chk("s3_pending_set", A_PENDING, 32'h8);
        apb_write(A_PENDING, 32'h8);
        read_chk("s3_pending_cleared", A_PENDING, 32'h0);
        chk("s3_no_irq", {31'd0, irq_valid}, 32'h0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_PENDING; pwdata = 32'h8;
        step();
        penable = 1'b1;
        irq_src = 8'h08;
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        irq_src = 8'h00;
        read_chk("s3_set_beats_clear", A_PENDING, 32'h8);

        // Higher priority preempts an unclaimed offer
        do_reset();
        apb_write(4'd0, 32'd2);
        apb_write(4'd5, 32'd7);
        apb_write(A_ENABLE, 32'h21);
        irq_src = 8'h01;
        step();
        step();
        chk("s4_valid", {31'd0, irq_valid}, 32'h1);
        chk("s4_id0", {29'd0, irq_id}, 32'd0);
        irq_src = 8'h21;
        step();
        chk("s4_id_ex", {29'd0, irq_id}, 32'd0);
        step();
        chk("s4_id_ex1", {29'd0, irq_id}, 32'd5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        read_chk("s4_status", A_STATUS, 32'h105);

        // Reset from IN_SERVICE
        preset = 1'b1;
        step();
        preset = 1'b0;
        chk("s5_valid", {31'd0, irq_valid}, 32'h0);
        chk("s5_id", {29'd0, irq_id}, 32'h0);
        chk("s5_prdata", prdata, 32'h0);
        read_chk("s5_status", A_STATUS, 32'h0);
        for (int i = 0; i < NUM_SRC; i++) begin
            read_chk($sformatf("s5_prio%0d", i), ADDR_W'(i), 32'h0);
        end
        chk("s5_valid_after", {31'd0, irq_valid}, 32'h0);

        // Unmapped read returns 0 with an error
        irq_src = '0;
        apb_write(A_ENABLE, 32'hFF);
        read_chk("s6_enable", A_ENABLE, 32'hFF);
        apb_read(4'd14, d, e);
        chk("s6_slverr", {31'd0, e}, 32'h1);
        chk("s6_prdata", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
